trace_capture: RTL and testbench

- Parametrised, synthesizable debug trace buffer for the multicycle transputer datapath.
- Replaces clock-only observation at the top level with on-chip capture of PC, instruction and ALU result on every PC update.
- Holds pre-trigger history in a ring buffer, stops a fixed number of samples after a PC-match trigger, then streams the entries out oldest-first.
- Sits beside TopLevel and taps PCVal, instruction, ALUOutResult and C_PCWrite.

---
 rtl/trace_pkg.sv | 17 +
 rtl/trace_ram.sv | 31 +++
 rtl/trace_capture.sv | 154 +++++++++++++++
 tb/tb_trace_capture.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared state type and entry sizing for the trace capture block.
// Defining TRACE_TIMESTAMP_EN appends a TS_W-bit timestamp to every stored entry.
package trace_pkg;

   typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, READ} trace_state_t;

   localparam int TS_W = 16;

   function automatic int entry_w(input int data_w);
`ifdef TRACE_TIMESTAMP_EN
      return 3*data_w + TS_W;
`else
      return 3*data_w;
`endif
   endfunction

endpackage

// File: rtl/trace_ram.sv
// DEPTH x W simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// The read register resets so the trace output is clean out of reset.
module trace_ram #(
   parameter int DEPTH = 32,
   parameter int W     = 48
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   rdata_q <= '0;
      else if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// Debug trace buffer: rings {pc, instr, alu} on each PC update, freezes POST_TRIG samples
// after a PC match, then streams entries oldest-first. Optional TRACE_TIMESTAMP_EN adds stamps.
module trace_capture
   import trace_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 32,
   parameter int POST_TRIG = 8
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         arm,
   input  logic                         abort,
   input  logic                         sample_en,
   input  logic [DATA_W-1:0]            trig_pc,
   input  logic [DATA_W-1:0]            pc_val,
   input  logic [DATA_W-1:0]            instr,
   input  logic [DATA_W-1:0]            alu_out,
   input  logic                         rd_req,
   output logic [entry_w(DATA_W)-1:0]   rd_data,
   output logic                         rd_valid,
   output logic                         rd_last,
   output logic                         busy,
   output logic                         done,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int ENTRY_W = entry_w(DATA_W);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] POST_N = CNT_W'(POST_TRIG);

   trace_state_t      state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr, rd_start;
   logic              wrapped_q, wrapped_d;
   logic [CNT_W-1:0]  count_q, count_d, post_cnt_q, post_cnt_d, rd_cnt_q, rd_cnt_d, rd_idx;
   logic              rd_valid_q, rd_last_q;
   logic              we, rd_issue, rd_is_last;
   logic [ENTRY_W-1:0] wdata;

   // History is only written while capturing; abort blocks both write and read issue.
   assign we         = !abort && sample_en && (state_q == ARMED || state_q == POST);
   assign rd_issue   = !abort && rd_req && (state_q == DONE || state_q == READ);
   assign rd_start   = wrapped_q ? wr_ptr_q : '0;
   assign rd_addr    = (state_q == DONE) ? rd_start : rd_ptr_q;
   assign rd_idx     = (state_q == DONE) ? '0 : rd_cnt_q;
   assign rd_is_last = (rd_idx == count_q - 1'b1);

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q, ts_d, ts_stamp;

   // Stamp = cycles elapsed since arm, saturating.
   assign ts_stamp = (ts_q == '1) ? ts_q : ts_q + 1'b1;
   assign ts_d     = (!abort && arm && state_q == IDLE) ? '0 : ts_stamp;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) ts_q <= '0;
      else        ts_q <= ts_d;
   end

   assign wdata = {pc_val, instr, alu_out, ts_stamp};
`else
   assign wdata = {pc_val, instr, alu_out};
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         wrapped_q  <= 1'b0;
         count_q    <= '0;
         post_cnt_q <= '0;
         rd_ptr_q   <= '0;
         rd_cnt_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         wrapped_q  <= wrapped_d;
         count_q    <= count_d;
         post_cnt_q <= post_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_valid_q <= rd_issue;
         rd_last_q  <= rd_issue && rd_is_last;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      wrapped_d  = wrapped_q;
      count_d    = count_q;
      post_cnt_d = post_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      rd_cnt_d   = rd_cnt_q;
      if (abort) begin
         state_d = IDLE;
         count_d = '0;
      end else begin
         unique case (state_q)
            IDLE: if (arm) begin
               state_d   = ARMED;
               wr_ptr_d  = '0;
               wrapped_d = 1'b0;
               count_d   = '0;
            end
            ARMED, POST: if (sample_en) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == '1)   wrapped_d = 1'b1;
               if (count_q != FULL)  count_d   = count_q + 1'b1;
               if (state_q == ARMED) begin
                  if (pc_val == trig_pc) begin
                     post_cnt_d = '0;
                     state_d    = (POST_TRIG == 0) ? DONE : POST;
                  end
               end else begin
                  post_cnt_d = post_cnt_q + 1'b1;
                  if (post_cnt_q + 1'b1 == POST_N) state_d = DONE;
               end
            end
            DONE, READ: if (rd_req) begin
               rd_ptr_d = rd_addr + 1'b1;
               rd_cnt_d = rd_idx + 1'b1;
               state_d  = rd_is_last ? IDLE : READ;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Abort also kills a response already on its way out.
   always_comb begin
      busy     = (state_q == ARMED) || (state_q == POST);
      done     = (state_q == DONE)  || (state_q == READ);
      rd_valid = rd_valid_q && !abort;
      rd_last  = rd_last_q  && !abort;
      count    = count_q;
   end

   trace_ram #(.DEPTH(DEPTH), .W(ENTRY_W)) u_ram (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata),
      .re_i    (rd_issue),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: two instances (POST_TRIG 8 and 0) on shared stimulus, checked
// against a queue model of "last DEPTH samples up to trigger + POST_TRIG".
module tb_trace_capture;
   import trace_pkg::*;

   localparam int DW    = 16;
   localparam int DEPTH = 32;
   localparam int EW    = entry_w(DW);
   localparam int CW    = $clog2(DEPTH) + 1;

   logic CLK = 1'b0, RST_N = 1'b0;
   logic arm = 1'b0, abort = 1'b0, sample_en = 1'b0, rd_req = 1'b0;
   logic [DW-1:0] trig_pc = '0, pc_val = '0, instr = '0, alu_out = '0;

   logic [EW-1:0] rd_data0, rd_data1, rd_data_s;
   logic          rv0, rv1, rl0, rl1, b0, b1, d0, d1, rv_s, rl_s, busy_s, done_s;
   logic [CW-1:0] c0, c1, count_s;
   logic          sel = 1'b0;

   int checks = 0, errors = 0, cyc = 0;
   logic [EW-1:0] hist[$];
   int  n_s, trig_idx;
   bit  cap_open;
   logic [DW-1:0] first_pc, last_pc;

   always #5 CLK = ~CLK;

   trace_capture #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(8)) u0 (
      .CLK(CLK), .RST_N(RST_N), .arm(arm), .abort(abort), .sample_en(sample_en),
      .trig_pc(trig_pc), .pc_val(pc_val), .instr(instr), .alu_out(alu_out), .rd_req(rd_req),
      .rd_data(rd_data0), .rd_valid(rv0), .rd_last(rl0), .busy(b0), .done(d0), .count(c0));

   trace_capture #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(0)) u1 (
      .CLK(CLK), .RST_N(RST_N), .arm(arm), .abort(abort), .sample_en(sample_en),
      .trig_pc(trig_pc), .pc_val(pc_val), .instr(instr), .alu_out(alu_out), .rd_req(rd_req),
      .rd_data(rd_data1), .rd_valid(rv1), .rd_last(rl1), .busy(b1), .done(d1), .count(c1));

   always_comb begin
      rd_data_s = sel ? rd_data1 : rd_data0;
      rv_s      = sel ? rv1 : rv0;
      rl_s      = sel ? rl1 : rl0;
      busy_s    = sel ? b1 : b0;
      done_s    = sel ? d1 : d0;
      count_s   = sel ? c1 : c0;
   end

   initial begin
      #3000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic do_abort();
      abort = 1'b1; step(); abort = 1'b0;
   endtask

   // gap==0 means a random 1..3 cycle spacing; rand_pc draws PCs from 0..63.
   task automatic run_capture(input int post, input logic [DW-1:0] trig, input bit rand_pc,
                              input int gap, input int maxs);
      int g;
      do_abort();
      trig_pc = trig; hist.delete(); n_s = 0; trig_idx = -1; cap_open = 1'b1;
      arm = 1'b1; step(); arm = 1'b0; cyc = 0;
      chk("arm_busy", 64'(busy_s), 64'd1);
      chk("arm_count", 64'(count_s), 64'd0);
      while (cap_open && n_s < maxs) begin
         g = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
         repeat (g - 1) step();
         pc_val    = rand_pc ? DW'($urandom_range(0, 63)) : DW'(2 * n_s);
         instr     = DW'($urandom);
         alu_out   = DW'($urandom);
         sample_en = 1'b1;
         step();
         sample_en = 1'b0;
         n_s++;
         if (trig_idx < 0 && pc_val == trig) trig_idx = n_s - 1;
         cap_open = (trig_idx < 0) || (n_s - 1 - trig_idx < post);
`ifdef TRACE_TIMESTAMP_EN
         hist.push_back({pc_val, instr, alu_out, (cyc > 65535) ? 16'hFFFF : 16'(cyc)});
`else
         hist.push_back({pc_val, instr, alu_out});
`endif
         if (hist.size() > DEPTH) void'(hist.pop_front());
         chk("cap_count", 64'(count_s), 64'((n_s < DEPTH) ? n_s : DEPTH));
         chk("cap_done", 64'(done_s), 64'(!cap_open));
         chk("cap_busy", 64'(busy_s), 64'(cap_open));
      end
   endtask

   task automatic read_all(input bit burst);
      int m;
      m = hist.size();
      for (int i = 0; i < m; i++) begin
         rd_req = 1'b1; step();
         if (!burst) rd_req = 1'b0;
         chk("rd_valid", 64'(rv_s), 64'd1);
         chk("rd_data", 64'(rd_data_s), 64'(hist[i]));
         chk("rd_last", 64'(rl_s), 64'(i == m - 1));
         chk("rd_done", 64'(done_s), 64'(i != m - 1));
         if (i == 0)     first_pc = rd_data_s[EW-1 -: DW];
         if (i == m - 1) last_pc  = rd_data_s[EW-1 -: DW];
         if (!burst && $urandom_range(0, 1) == 1) begin
            step();
            chk("rd_gap", 64'(rv_s), 64'd0);
         end
      end
      rd_req = 1'b1; step();
      chk("rd_after_last", 64'(rv_s), 64'd0);
      rd_req = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid", 64'(rv0 | rv1), 64'd0);
      chk("rst_last", 64'(rl0 | rl1), 64'd0);
      chk("rst_busy", 64'(b0 | b1), 64'd0);
      chk("rst_done", 64'(d0 | d1), 64'd0);
      chk("rst_count", 64'(c0 | c1), 64'd0);
      chk("rst_data", 64'(rd_data0 | rd_data1), 64'd0);
      @(negedge CLK); RST_N = 1'b1;
      step();

      // Basic trigger
      sel = 1'b0;
      run_capture(8, 16'h0010, 1'b0, 3, 200);
      chk("basic_count", 64'(count_s), 64'd17);
      read_all(1'b1);
      chk("basic_first", 64'(first_pc), 64'h0000);
      chk("basic_last", 64'(last_pc), 64'h0020);

      // Wrap
      run_capture(8, 16'h0080, 1'b0, 3, 200);
      chk("wrap_count", 64'(count_s), 64'd32);
      read_all(1'b0);
      chk("wrap_first", 64'(first_pc), 64'h0052);
      chk("wrap_last", 64'(last_pc), 64'h0090);

      // Immediate trigger on the POST_TRIG=0 instance
      sel = 1'b1;
      run_capture(0, 16'h0000, 1'b0, 3, 50);
      chk("imm_done", 64'(done_s), 64'd1);
      chk("imm_count", 64'(count_s), 64'd1);
      read_all(1'b0);

      // Randomised captures on both instances
      for (int r = 0; r < 8; r++) begin
         sel = r[0];
         run_capture(sel ? 0 : 8, DW'($urandom_range(0, 63)), 1'b1, 0, 400);
         if (!cap_open) read_all(1'($urandom_range(0, 1)));
      end

      // Abort in POST after three post samples, then re-arm
      sel = 1'b0;
      run_capture(8, 16'h0000, 1'b0, 1, 4);
      chk("post_busy", 64'(busy_s), 64'd1);
      do_abort();
      chk("abort_busy", 64'(busy_s), 64'd0);
      chk("abort_done", 64'(done_s), 64'd0);
      chk("abort_count", 64'(count_s), 64'd0);
      arm = 1'b1; step(); arm = 1'b0;
      chk("rearm_count", 64'(count_s), 64'd0);
      chk("rearm_busy", 64'(busy_s), 64'd1);
      do_abort();

      // Arm and abort together
      arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
      chk("armabort_busy", 64'(busy_s), 64'd0);
      step();
      chk("armabort_busy2", 64'(busy_s), 64'd0);

      // Abort suppresses an in-flight response
      run_capture(8, 16'h0010, 1'b0, 1, 100);
      rd_req = 1'b1; step();
      chk("inflight_valid", 64'(rv_s), 64'd1);
      abort = 1'b1; #1;
      chk("inflight_suppr", 64'(rv_s), 64'd0);
      step(); abort = 1'b0; rd_req = 1'b0;
      chk("inflight_done", 64'(done_s), 64'd0);
      chk("inflight_after", 64'(rv_s), 64'd0);

      // Reset mid-read
      run_capture(8, 16'h0010, 1'b0, 2, 100);
      rd_req = 1'b1; step(); step();
      chk("midrd_valid", 64'(rv_s), 64'd1);
      RST_N = 1'b0; #1;
      chk("midrd_rst_valid", 64'(rv_s), 64'd0);
      chk("midrd_rst_done", 64'(done_s), 64'd0);
      chk("midrd_rst_count", 64'(count_s), 64'd0);
      step(); step();
      @(negedge CLK); RST_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("midrd_post_valid", 64'(rv_s), 64'd0);
         chk("midrd_post_done", 64'(done_s), 64'd0);
      end
      rd_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
